// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter.
//   state_t     : measurement FSM states (IDLE, GATE, DONE)
//   gate_cnt_w  : width of the gate-window counter for a given window length
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    // Gate counter only has to reach GATE_CYCLES-1, so $clog2 is enough.
    // Clamped to 1 bit so a 2-cycle window still gets a real counter.
    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
    endfunction

    localparam int DEFAULT_GATE_CYCLES = 50000000;
    localparam int DEFAULT_GATE_W      = gate_cnt_w(DEFAULT_GATE_CYCLES);

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser plus rising-edge detector for one asynchronous input.
//   clk, reset_n : clock, async active-low reset
//   async_in     : asynchronous input
//   level_sync   : synchronised level (last synchroniser stage)
//   rise_pulse   : registered one-cycle pulse per synchronised rising edge
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level_sync,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
            rise_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign level_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter: f_sig = freq_count * f_clk / GATE_CYCLES.
//   clk, reset_n : clock, async active-low reset
//   sig_in       : asynchronous signal being measured
//   start        : one-cycle request for a single window (honoured in IDLE only)
//   continuous   : while high, windows run back-to-back (period GATE_CYCLES+1)
//   busy         : high during GATE and DONE
//   edge_tick    : one pulse per synchronised rising edge of sig_in
//   freq_count   : edge count of the last completed window
//   count_valid  : one-cycle pulse, coincident with freq_count/overflow updating
//   overflow     : the reported window saturated its edge counter
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             edge_tick,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic             overflow
);

    localparam int             GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf;

    // Only the edge pulse is needed here; the level output serves other users.
    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .async_in   (sig_in),
        .level_sync (),
        .rise_pulse (edge_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start || continuous) state_nxt = GATE;
            GATE:    if (gate_cnt == GATE_LAST) state_nxt = DONE;
            DONE:    state_nxt = continuous ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == GATE) || (state == DONE);

    // freq_count, overflow and count_valid are all loaded on the clock that
    // ends DONE, so the valid pulse lines up with the new result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
            freq_count  <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            case (state)
                GATE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    // The last gate cycle's edge still lands in edge_cnt
                    // before DONE reads it.
                    if (edge_tick) begin
                        if (&edge_cnt) ovf      <= 1'b1;
                        else           edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                DONE: begin
                    freq_count  <= edge_cnt;
                    overflow    <= ovf;
                    count_valid <= 1'b1;
                    gate_cnt    <= '0;
                    edge_cnt    <= '0;
                    ovf         <= 1'b0;
                end
                default: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle gate window.
//   dut  : CNT_W=32 for the main measurements
//   dut3 : CNT_W=3 for saturation / overflow
module tb_freq_meter;

    localparam int GATE = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, continuous = 1'b0;
    logic        start3 = 1'b0;
    logic        sig_in = 1'b0, sig3 = 1'b0;
    logic        busy, edge_tick, count_valid, overflow;
    logic [31:0] freq_count;
    logic        busy3, edge_tick3, count_valid3, overflow3;
    logic [2:0]  freq_count3;

    // square-wave generators: toggle every 'half' cycles, else hold a level
    bit   tog_en = 1'b0, tog3_en = 1'b0;
    logic hold = 1'b0, hold3 = 1'b0;
    int   half = 5, half3 = 2, tc = 0, tc3 = 0;

    int n_tests = 0, n_fail = 0;
    int cv_n, cv_edge, busy_n, tick_n;
    logic [31:0] fc;
    logic        ov;
    int cve [8];
    logic [31:0] cvf [8];

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy), .edge_tick(edge_tick),
        .freq_count(freq_count), .count_valid(count_valid), .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .sig_in(sig3), .start(start3),
        .continuous(1'b0), .busy(busy3), .edge_tick(edge_tick3),
        .freq_count(freq_count3), .count_valid(count_valid3), .overflow(overflow3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tog_en) begin
            if (tc >= half - 1) begin sig_in = ~sig_in; tc = 0; end
            else tc++;
        end else begin
            sig_in = hold; tc = 0;
        end
        if (tog3_en) begin
            if (tc3 >= half3 - 1) begin sig3 = ~sig3; tc3 = 0; end
            else tc3++;
        end else begin
            sig3 = hold3; tc3 = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then watch 130 cycles. cv_edge counts clock edges from
    // the edge that sampled start to the edge that raised count_valid.
    task automatic watch(input int restart_at);
        cv_n = 0; cv_edge = -1; busy_n = 0; tick_n = 0; fc = '0; ov = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) busy_n++;
            if (edge_tick) tick_n++;
            if (count_valid) begin cv_n++; cv_edge = c - 1; fc = freq_count; ov = overflow; end
            start = (c == restart_at);
        end
    endtask

    task automatic watch3();
        cv_n = 0; fc = '0; ov = 1'b0;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            if (c > 1) @(negedge clk);
            if (count_valid3) begin cv_n++; fc = 32'(freq_count3); ov = overflow3; end
        end
    endtask

    initial begin
        int cv_seen;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(edge_tick), 0);
        check("rst_count", freq_count, 0);
        check("rst_valid", 32'(count_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // period-10 input, single shot
        tog_en = 1'b1;
        repeat (50) @(negedge clk);
        watch(0);
        check("t1_cv_n", 32'(cv_n), 1);
        check("t1_cv_edge", 32'(cv_edge), 101);
        check("t1_busy_cycles", 32'(busy_n), 101);
        check("t1_count", fc, 10);
        check("t1_ovf", 32'(ov), 0);
        repeat (20) @(negedge clk);
        check("t1_hold_count", freq_count, 10);
        check("t1_idle_busy", 32'(busy), 0);

        // static input: low, then high
        tog_en = 1'b0; hold = 1'b0;
        repeat (10) @(negedge clk);
        watch(0);
        check("t2_lo_cv_n", 32'(cv_n), 1);
        check("t2_lo_count", fc, 0);
        check("t2_lo_ticks", 32'(tick_n), 0);
        hold = 1'b1;
        repeat (10) @(negedge clk);
        watch(0);
        check("t2_hi_cv_n", 32'(cv_n), 1);
        check("t2_hi_count", fc, 0);
        check("t2_hi_ticks", 32'(tick_n), 0);

        // 3-bit counter, period-4 input: 25 edges saturate at 7
        tog3_en = 1'b1;
        repeat (20) @(negedge clk);
        watch3();
        check("t3_cv_n", 32'(cv_n), 1);
        check("t3_sat_count", fc, 7);
        check("t3_sat_ovf", 32'(ov), 1);
        tog3_en = 1'b0; hold3 = 1'b0;
        repeat (10) @(negedge clk);
        watch3();
        check("t3_zero_count", fc, 0);
        check("t3_zero_ovf", 32'(ov), 0);

        // continuous: 5 windows, drop continuous 50 cycles into the 5th
        tog_en = 1'b1;
        repeat (20) @(negedge clk);
        cv_n = 0;
        for (int k = 0; k < 8; k++) begin cve[k] = 0; cvf[k] = '0; end
        @(negedge clk); continuous = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (count_valid) begin
                if (cv_n < 8) begin cve[cv_n] = c - 1; cvf[cv_n] = freq_count; end
                cv_n++;
            end
            if (cv_n == 4 && c == cve[3] + 50) continuous = 1'b0;
        end
        check("t4_cv_n", 32'(cv_n), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_edge%0d", k), 32'(cve[k]), 32'(101 * (k + 1)));
            check($sformatf("t4_count%0d", k), cvf[k], 10);
        end
        check("t4_end_busy", 32'(busy), 0);

        // start while busy is ignored
        watch(20);
        check("t5_cv_n", 32'(cv_n), 1);
        check("t5_cv_edge", 32'(cv_edge), 101);
        check("t5_count", fc, 10);

        // reset 30 cycles into GATE
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (29) @(negedge clk);
        check("t6_pre_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_count", freq_count, 0);
        check("t6_ovf", 32'(overflow), 0);
        check("t6_valid", 32'(count_valid), 0);
        check("t6_tick", 32'(edge_tick), 0);
        cv_seen = 0;
        repeat (5) begin @(negedge clk); if (count_valid) cv_seen++; end
        reset_n = 1'b1;
        repeat (120) begin @(negedge clk); if (count_valid) cv_seen++; end
        check("t6_no_valid", 32'(cv_seen), 0);
        check("t6_idle_busy", 32'(busy), 0);
        watch(0);
        check("t6_fresh_cv_n", 32'(cv_n), 1);
        check("t6_fresh_count", fc, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
